// File: rtl/accumulator_core_if.sv
// Instruction-fetch bus between accumulator_core (master) and its
// instruction memory (slave): address/request out, word/valid back.
interface accumulator_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 4
);
  localparam int IW = 4 + DATA_WIDTH;

  logic [PC_WIDTH-1:0] iaddr;
  logic                ireq;
  logic [IW-1:0]       idata;
  logic                ivalid;

  modport master (output iaddr, ireq, input idata, ivalid);
  modport slave  (input iaddr, ireq, output idata, ivalid);
endinterface

// File: rtl/accumulator_core.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/HALT control, ALU, register file
// and Z/C flags, fetching over a request/valid instruction bus.
module accumulator_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 4,
  parameter int NREG       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  accumulator_core_if.master    bus,
  output logic [DATA_WIDTH-1:0] o_acc_out,
  output logic                  o_z_flag,
  output logic                  o_c_flag,
  output logic                  o_halted
);
  localparam int IW = 4 + DATA_WIDTH;
  localparam int RA = $clog2(NREG);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
    OP_ANDI = 4'h4, OP_XORI = 4'h5, OP_MOV = 4'h6, OP_LD   = 4'h7,
    OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_AND = 4'hA, OP_XOR  = 4'hB,
    OP_JMP  = 4'hC, OP_JZ   = 4'hD, OP_JC  = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [IW-1:0]         r_ir;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_z;
  logic                  r_c;
  logic [DATA_WIDTH-1:0] r_regs [NREG];

  state_t                w_state_nxt;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic [IW-1:0]         w_ir_nxt;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic                  w_acc_we;
  logic                  w_z_nxt;
  logic                  w_c_nxt;
  logic                  w_reg_we;
  opcode_t               w_op;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [RA-1:0]         w_rsel;
  logic [DATA_WIDTH-1:0] w_rn;
  logic [DATA_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;

  assign w_op      = opcode_t'(r_ir[IW-1 -: 4]);
  assign w_imm     = r_ir[DATA_WIDTH-1:0];
  assign w_rsel    = w_imm[RA-1:0];
  assign w_rn      = r_regs[w_rsel];
  // Opcodes 8-B take a register operand, 1-5 the immediate.
  assign w_operand = w_op[3] ? w_rn : w_imm;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_operand};
  assign w_diff    = {1'b0, r_acc} - {1'b0, w_operand};

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_nxt   = r_acc;
    w_acc_we    = 1'b0;
    w_z_nxt     = r_z;
    w_c_nxt     = r_c;
    w_reg_we    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.ivalid) begin
          w_ir_nxt    = bus.idata;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc + PC_WIDTH'(1);
        case (w_op)
          OP_LDI:          begin w_acc_nxt = w_imm;                 w_acc_we = 1'b1; end
          OP_ADDI, OP_ADD: begin {w_c_nxt, w_acc_nxt} = w_sum;      w_acc_we = 1'b1; end
          OP_SUBI, OP_SUB: begin {w_c_nxt, w_acc_nxt} = w_diff;     w_acc_we = 1'b1; end
          OP_ANDI, OP_AND: begin w_acc_nxt = r_acc & w_operand;     w_acc_we = 1'b1; end
          OP_XORI, OP_XOR: begin w_acc_nxt = r_acc ^ w_operand;     w_acc_we = 1'b1; end
          OP_MOV:          w_reg_we = 1'b1;
          OP_LD:           begin w_acc_nxt = w_rn;                  w_acc_we = 1'b1; end
          OP_JMP:          w_pc_nxt = w_imm[PC_WIDTH-1:0];
          OP_JZ:           if (r_z) w_pc_nxt = w_imm[PC_WIDTH-1:0];
          OP_JC:           if (r_c) w_pc_nxt = w_imm[PC_WIDTH-1:0];
          OP_HALT: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = S_HALT;
          end
          default: ;
        endcase
        if (w_acc_we) w_z_nxt = (w_acc_nxt == '0);
      end
      default: ;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_acc   <= w_acc_nxt;
      r_z     <= w_z_nxt;
      r_c     <= w_c_nxt;
    end
  end

  // NOTE: the register file is architecturally zero after reset, so it is
  // built from reset flops rather than left to map onto an unreset RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_reg_we) begin
      r_regs[w_rsel] <= r_acc;
    end
  end

  assign bus.iaddr = r_pc;
  assign bus.ireq  = (r_state == S_FETCH);
  assign o_halted  = (r_state == S_HALT);
  assign o_acc_out = r_acc;
  assign o_z_flag  = r_z;
  assign o_c_flag  = r_c;
endmodule

// File: tb/tb_accumulator_core.sv
// Bench for accumulator_core: an instruction-level reference model checked
// every cycle, directed programs with literal end results, and a 12-bit build.
module tb_accumulator_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build: DATA_WIDTH=8, PC_WIDTH=4, NREG=4
  accumulator_core_if #(.DATA_WIDTH(8), .PC_WIDTH(4)) bus0 ();
  logic [7:0] acc0;
  logic       z0, c0, h0;
  accumulator_core #(.DATA_WIDTH(8), .PC_WIDTH(4), .NREG(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.master),
    .o_acc_out(acc0), .o_z_flag(z0), .o_c_flag(c0), .o_halted(h0));

  // Wide build: DATA_WIDTH=12, NREG=8, zero-wait memory
  accumulator_core_if #(.DATA_WIDTH(12), .PC_WIDTH(4)) bus1 ();
  logic [11:0] acc1;
  logic        z1, c1, h1;
  accumulator_core #(.DATA_WIDTH(12), .PC_WIDTH(4), .NREG(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.master),
    .o_acc_out(acc1), .o_z_flag(z1), .o_c_flag(c1), .o_halted(h1));

  logic [11:0] rom  [16];
  logic [15:0] rom1 [16];
  logic [11:0] prog [$];
  logic [11:0] junk;
  logic        ivalid_drv;
  int          max_wait = 0;
  int          wait_left = -1;

  assign bus0.idata  = rst_n ? rom[bus0.iaddr] : junk;
  assign bus0.ivalid = ivalid_drv;
  assign bus1.idata  = rom1[bus1.iaddr];
  assign bus1.ivalid = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model, advanced once per clock edge
  int          m_pc, m_acc, m_retired, m_subi_count;
  int          m_regs [4];
  bit          m_z, m_c, m_halted, m_exec, m_valid = 1'b0;
  logic [11:0] m_ir;

  task automatic model_execute();
    int op, imm, sel, opnd, nxt;
    op   = int'(m_ir[11:8]);
    imm  = int'(m_ir[7:0]);
    sel  = imm % 4;
    opnd = (op >= 8) ? m_regs[sel] : imm;
    nxt  = (m_pc + 1) % 16;
    case (op)
      1:      m_acc = imm;
      2, 8:   begin m_c = (m_acc + opnd) > 255; m_acc = (m_acc + opnd) % 256; end
      3, 9:   begin m_c = m_acc < opnd; m_acc = (m_acc - opnd + 256) % 256; end
      4, 10:  m_acc = m_acc & opnd;
      5, 11:  m_acc = m_acc ^ opnd;
      6:      m_regs[sel] = m_acc;
      7:      m_acc = m_regs[sel];
      12:     nxt = imm % 16;
      13:     if (m_z) nxt = imm % 16;
      14:     if (m_c) nxt = imm % 16;
      15:     begin nxt = m_pc; m_halted = 1'b1; end
      default: ;
    endcase
    if ((op >= 1 && op <= 5) || (op >= 7 && op <= 11)) m_z = (m_acc == 0);
    if (op == 3) m_subi_count++;
    m_pc = nxt;
    m_retired++;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_pc = 0; m_acc = 0; m_z = 1'b0; m_c = 1'b0;
      m_halted = 1'b0; m_exec = 1'b0; m_ir = '0;
      m_retired = 0; m_subi_count = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
    end else if (m_valid && !m_halted) begin
      if (m_exec) begin
        model_execute();
        m_exec = 1'b0;
      end else if (ivalid_drv) begin
        m_ir   = rom[m_pc];
        m_exec = 1'b1;
      end
    end
  end

  // Input driver, settled shortly after the falling edge
  always @(negedge clk) begin
    #1;
    junk = 12'($urandom);
    if (rst_n && m_valid && !m_halted && !m_exec) begin
      if (wait_left < 0) wait_left = $urandom_range(0, max_wait);
      ivalid_drv = (wait_left == 0);
      wait_left  = wait_left - 1;
    end else begin
      ivalid_drv = 1'($urandom_range(0, 1));
    end
  end

  // Every-cycle comparison of the default build against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("acc",    32'(acc0),       32'(m_acc));
      check("z",      32'(z0),         32'(m_z));
      check("c",      32'(c0),         32'(m_c));
      check("halted", 32'(h0),         32'(m_halted));
      check("ireq",   32'(bus0.ireq),  32'(!m_halted && !m_exec));
      check("iaddr",  32'(bus0.iaddr), 32'(m_pc));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_iaddr",  32'(bus0.iaddr), 32'h0);
    check("rst_ireq",   32'(bus0.ireq),  32'h1);
    check("rst_acc",    32'(acc0),       32'h0);
    check("rst_zc",     32'({z0, c0}),   32'h0);
    check("rst_halted", 32'(h0),         32'h0);
  endtask

  task automatic start_prog();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = (i < prog.size()) ? prog[i] : 12'hF00;
    wait_left = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!m_halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(m_halted), 32'h1);
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_end(input string name, input logic [7:0] acc,
                            input logic z, input logic c, input logic [3:0] pc);
    check({name, "_acc"},   32'(acc0),          32'(acc));
    check({name, "_zc"},    32'({z0, c0}),      32'({z, c}));
    check({name, "_halt"},  32'({h0, bus0.ireq}), 32'h2);
    check({name, "_pc"},    32'(bus0.iaddr),    32'(pc));
  endtask

  initial begin
    ivalid_drv = 1'b0;
    junk = '0;
    for (int i = 0; i < 16; i++) rom[i] = 12'hF00;
    for (int i = 0; i < 16; i++) rom1[i] = 16'hF000;
    rom1[0] = 16'h1123;  // LDI 0x123
    rom1[1] = 16'h600D;  // MOV R5 (upper imm bits ignored)
    rom1[2] = 16'h1FFF;  // LDI 0xFFF
    rom1[3] = 16'h2001;  // ADDI 1
    rom1[4] = 16'hF000;  // HALT

    // Arithmetic and flags
    prog = '{12'h1F0, 12'h220, 12'hF00};
    start_prog(); run_to_halt(100);
    expect_end("addi_carry", 8'h10, 1'b0, 1'b1, 4'd2);
    prog = '{12'h1F0, 12'h220, 12'h310, 12'h301, 12'h5FF, 12'hF00};
    start_prog(); run_to_halt(100);
    expect_end("sub_xor", 8'h00, 1'b1, 1'b1, 4'd5);

    // Register file
    prog = '{12'h105, 12'h606, 12'h103, 12'h802, 12'hF00};
    start_prog(); run_to_halt(100);
    expect_end("reg_add", 8'h08, 1'b0, 1'b0, 4'd4);
    prog = '{12'h105, 12'h606, 12'h103, 12'h802, 12'h701, 12'hF00};
    start_prog(); run_to_halt(100);
    expect_end("reg_ld", 8'h00, 1'b1, 1'b0, 4'd5);

    // Count-down loop, zero-wait then with 0-3 wait cycles per fetch
    prog = '{12'h103, 12'h301, 12'hD04, 12'hC01, 12'hF00};
    max_wait = 0;
    start_prog(); run_to_halt(200);
    expect_end("loop", 8'h00, 1'b1, 1'b0, 4'd4);
    check("loop_subi_count", 32'(m_subi_count), 32'd3);
    max_wait = 3;
    start_prog(); run_to_halt(600);
    expect_end("loop_wait", 8'h00, 1'b1, 1'b0, 4'd4);
    check("loop_wait_subi_count", 32'(m_subi_count), 32'd3);
    max_wait = 0;

    // Reset asserted in the middle of an EXEC cycle
    start_prog();
    begin
      int n = 0;
      while (!(m_retired >= 3 && m_exec) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("mid_exec_reached", 32'(m_exec), 32'h1);
      check("mid_exec_acc_nonzero", 32'(acc0 != 8'h00), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_acc",   32'(acc0),                 32'h0);
      check("mid_rst_state", 32'({h0, bus0.ireq, z0, c0}), 32'h4);
      check("mid_rst_iaddr", 32'(bus0.iaddr),           32'h0);
    end

    // Register ops, conditional jumps on carry
    prog = '{12'h10C, 12'h603, 12'h10A, 12'hA03, 12'hB03, 12'h903, 12'hE08, 12'hF00,
             12'h40F, 12'h700, 12'hE0D, 12'hF00, 12'hF00, 12'h000, 12'h555, 12'hF00};
    start_prog(); run_to_halt(200);
    expect_end("mix", 8'h55, 1'b0, 1'b1, 4'd15);

    // Sixteen NOPs: the fetch address wraps back to zero
    prog = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
             12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    start_prog();
    repeat (30) @(negedge clk);
    check("wrap_pc15", 32'(bus0.iaddr), 32'd15);
    repeat (2) @(negedge clk);
    check("wrap_pc0",  32'(bus0.iaddr), 32'd0);
    check("wrap_ireq", 32'(bus0.ireq),  32'h1);

    // 12-bit build has run its program since the last reset release
    check("w12_acc",  32'(acc1),          32'h000);
    check("w12_zc",   32'({z1, c1}),      32'h3);
    check("w12_halt", 32'({h1, bus1.ireq}), 32'h2);
    check("w12_pc",   32'(bus1.iaddr),    32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/accumulator_core.md
# accumulator_core

Parametrised successor to the single-cycle accumulator datapath: one synthesizable core containing program counter, instruction register, decoder, ALU, accumulator, a parametrised register file and Z/C flags. It adds conditional jumps and HALT. Instructions are fetched from an external instruction memory over a request/valid handshake, so the block works with both combinational ROM and multi-cycle memory. It sits between the instruction memory (memory/rom16x8 class) and the top-level testbench.

## Interface
- DATA_WIDTH, 8: accumulator, register and immediate width.
- PC_WIDTH, 4: program counter / instruction address width; must be ≤ DATA_WIDTH.
- NREG, 4: number of general registers R0..R(NREG-1); power of two, ≥2. RA = log2(NREG).
- Instruction width IW = 4 + DATA_WIDTH: opcode = IDATA[IW-1:IW-4], imm = IDATA[DATA_WIDTH-1:0].

- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-low reset.
- IADDR  out  PC_WIDTH  fetch address (= PC).
- IREQ  out  1  fetch request; high only in FETCH.
- IDATA  in  IW  instruction word; sampled only when IREQ && IVALID.
- IVALID  in  1  instruction memory response valid.
- ACC_OUT  out  DATA_WIDTH  accumulator.
- Z_FLAG  out  1  zero flag.
- C_FLAG  out  1  carry/borrow flag.
- HALTED  out  1  core in HALT state.

## Operation
- States: FETCH, EXEC, HALT. RST low at an edge → FETCH, PC=0, IR=0, ACC=0, all registers 0, Z=0, C=0; outputs IADDR=0, IREQ=1 after reset, ACC_OUT=0, flags 0, HALTED=0. Reset overrides any state, including mid-fetch and HALT.
- FETCH: IREQ=1, IADDR=PC. IVALID high at an edge → IR<=IDATA, go EXEC. IVALID low → stay; PC and IADDR held stable.
- EXEC: execute IR; PC<=PC+1 (wraps 2^PC_WIDTH-1 → 0) unless a jump is taken; go FETCH. IREQ=0; IVALID ignored.
- HALT: HALTED=1, IREQ=0, all state frozen; exit only via reset.
- Opcodes (n = imm[RA-1:0]; Rn with upper imm bits ignored):
  - 0 NOP.
  - 1 LDI: ACC<=imm. 2 ADDI: ACC<=ACC+imm. 3 SUBI: ACC<=ACC-imm.
  - 4 ANDI: ACC&imm. 5 XORI: ACC^imm.
  - 6 MOV: Rn<=ACC. 7 LD: ACC<=Rn.
  - 8 ADD: ACC+Rn. 9 SUB: ACC-Rn. A AND: ACC&Rn. B XOR: ACC^Rn.
  - C JMP: PC<=imm[PC_WIDTH-1:0]. D JZ: jump if Z=1. E JC: jump if C=1.
  - F HALT: PC not incremented; go HALT.
- Arithmetic: done in DATA_WIDTH+1 bits. ADD/ADDI: C = carry out. SUB/SUBI: C = borrow (1 iff ACC < operand unsigned); result wraps modulo 2^DATA_WIDTH.
- Flags: Z<=(new ACC==0) on every ACC write (opcodes 1-5, 7-B). C changes only on ADD/ADDI/SUB/SUBI. NOP/MOV/jumps/HALT leave both flags unchanged.
- JZ/JC test the flag values present at the start of EXEC, i.e. as left by the previous instruction.

## Timing
- Zero-wait memory (IVALID tied high): 2 cycles per instruction; reset release → first IR load at the 1st edge, first result at the 2nd edge.
- Each extra IVALID-low cycle in FETCH adds one cycle. No other stalls.
- ACC, registers, flags and PC all update at the EXEC edge. ACC_OUT and flags are registered outputs. IREQ/IADDR/HALTED are decoded from state/PC only, with no combinational path from IDATA or IVALID.
- HALTED rises one edge after the HALT instruction's EXEC cycle begins, i.e. at its EXEC edge.

## Test plan
- Reset: hold RST=0 with random IDATA/IVALID for 3 cycles → PC=0, ACC_OUT=0, Z=C=0, HALTED=0, IREQ=1. Assert RST=0 mid-EXEC → same values next edge.
- Arithmetic/flags (DATA_WIDTH=8): LDI 0xF0, ADDI 0x20 → ACC=0x10, C=1, Z=0. SUBI 0x10 → ACC=0x00, Z=1, C=0. SUBI 0x01 → ACC=0xFF, C=1. XORI 0xFF → ACC=0x00, Z=1, C still 1.
- Register file: LDI 5, MOV R2, LDI 3, ADD R2 → ACC=8. MOV with imm=0x06 (NREG=4) writes R2. LD R1 → ACC=0, Z=1.
- Branches: count-down loop LDI 3; SUBI 1; JZ 4; JMP 1; HALT → SUBI executes 3 times, ACC=0, HALTED=1 at PC=4, IREQ=0 afterwards forever.
- Wait states: IVALID low for 0-3 random cycles per fetch on the branch program → identical final ACC/flags/PC; IADDR stable during every wait.
- PC wrap/params: 16 NOPs with PC_WIDTH=4 → IADDR returns to 0. Rerun the arithmetic test with DATA_WIDTH=12, NREG=8: 0xFFF+1 → ACC=0, C=1, Z=1.
